// File: rtl/mux4to1_rr_merge.sv
// mux4to1_rr_merge: four-channel round-robin merger onto one registered, channel-tagged output
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_data0..3, in_valid     four input channels (payload, offer bits)
//   in_ready                  one-hot accept for the granted channel
//   out_data, out_sel         registered payload and its source channel index
//   out_valid, out_ready      output handshake
module mux4to1_rr_merge #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data0,
   input  logic [WIDTH-1:0] in_data1,
   input  logic [WIDTH-1:0] in_data2,
   input  logic [WIDTH-1:0] in_data3,
   input  logic [3:0]       in_valid,
   output logic [3:0]       in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_sel,
   output logic             out_valid,
   input  logic             out_ready
);
   logic [WIDTH-1:0] in_arr [4];
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]       out_sel_q, out_sel_d, ptr_q, ptr_d, g, idx;
   logic             out_valid_q, out_valid_d, found, load;
   assign in_arr[0] = in_data0;
   assign in_arr[1] = in_data1;
   assign in_arr[2] = in_data2;
   assign in_arr[3] = in_data3;
   // Scan from the farthest offset down so the last hit is the one closest to ptr.
   always_comb begin
      found = 1'b0;
      g     = ptr_q;
      idx   = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr_q + 2'(k);
         if (in_valid[idx]) begin
            found = 1'b1;
            g     = idx;
         end
      end
   end
   assign load     = (~out_valid_q | out_ready) & found & ~rst;
   assign in_ready = load ? 4'(4'b0001 << g) : 4'b0000;
   always_comb begin
      out_data_d  = load ? in_arr[g] : out_data_q;
      out_sel_d   = load ? g : out_sel_q;
      out_valid_d = load | (out_valid_q & ~out_ready);
      ptr_d       = load ? g + 2'd1 : ptr_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;
endmodule
